mat_mult_seq: RTL and testbench
===============================

# mat_mult_seq

Sequential, parametrised GF(2) matrix multiplier computing C = A·B, where multiply is AND and add is XOR. A is an A_ROWS×A_COLS bit matrix and B is an A_COLS×B_COLS bit matrix. It is the multi-column, multi-cycle successor to the single-shot combinational-plus-register multiplier. It sits on the datapath between operand producers and result consumers, with valid/ready handshakes on both sides.

## Interface
- A_ROWS, 4, rows of A and C
- A_COLS, 8, columns of A and rows of B (inner dimension)
- B_COLS, 1, columns of B and C
- STEP, 1, inner-dimension terms processed per cycle; must divide A_COLS; NSTEP = A_COLS/STEP
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands valid
- in_ready  out  1  block accepts operands
- A_data_in  in  A_ROWS*A_COLS  element (r,k) at bit r*A_COLS+k
- B_data_in  in  A_COLS*B_COLS  element (k,c) at bit k*B_COLS+c
- out_valid  out  1  C_data_out valid
- out_ready  in  1  consumer accepts result
- C_data_out  out  A_ROWS*B_COLS  element (r,c) at bit r*B_COLS+c
- busy  out  1  state != IDLE
- C_parity  out  1  only with MAT_MULT_SEQ_PARITY_EN

## Operation
- Arithmetic: C(r,c) = XOR over k of (A(r,k) & B(k,c)). Carries never exist and widths never grow.
- The FSM has three states: IDLE, CALC and HOLD.
- IDLE:
  - in_ready = 1.
  - On in_valid: register A and B, clear the accumulator, set k_cnt = 0, and go to CALC.
- CALC:
  - in_ready = 0.
  - Each cycle: acc(r,c) ^= XOR over k in [k_cnt, k_cnt+STEP-1] of A(r,k)&B(k,c), then k_cnt += STEP.
  - On the cycle where k_cnt = A_COLS-STEP: load C_data_out with the final acc, set out_valid = 1, and go to HOLD.
- HOLD:
  - out_valid = 1 and C_data_out is stable.
  - in_ready = out_ready, so a new operand set may be accepted in the same cycle the result is popped.
  - out_ready & in_valid: capture new operands, clear out_valid, go to CALC.
  - out_ready & !in_valid: clear out_valid, go to IDLE.
  - !out_ready: stay; in_valid is ignored and operands are not captured.
- C_data_out keeps its last value after the pop and changes only on the next final CALC cycle.
- Operand registers make the block independent of A_data_in and B_data_in after acceptance.
- Reset:
  - Asynchronous: takes effect immediately, including mid-CALC or in HOLD.
  - State goes to IDLE; k_cnt and acc are cleared.
  - Reset values: out_valid = 0, C_data_out = 0, C_parity = 0, busy = 0, in_ready = 1.
  - An in-flight result is discarded.

## Timing
- Acceptance edge t0 (in_valid & in_ready high).
- CALC occupies edges t0+1 … t0+NSTEP. out_valid is high starting the cycle after edge t0+NSTEP.
- Latency is NSTEP cycles from acceptance to out_valid.
- With out_ready and in_valid held high, one result is produced every NSTEP+1 cycles.
- in_ready and busy are decoded from registered state only. in_ready in HOLD is the only output with a combinational input path (from out_ready).
- No combinational path runs from in_valid to any output.

## Configuration
- MAT_MULT_SEQ_PARITY_EN
  - Defined: adds the C_parity output, the XOR of all bits of C_data_out. It is registered on the same edge as C_data_out and held with it; reset value 0.
  - Undefined: the port and its logic are absent, and all other behaviour is identical.

## Test plan
- Identity: default params; A_data_in=32'h08040201, B_data_in=8'h0F → out_valid 8 cycles after acceptance; C_data_out=4'hF.
- Parity: A_data_in=32'hFFFFFFFF with B_data_in=8'h07 → C_data_out=4'hF and C_parity=0. Then B_data_in=8'h03 → C_data_out=4'h0 and C_parity=0.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD while in_valid=1 with new operands → C_data_out, out_valid=1 and in_ready=0 stay stable, and no capture occurs. Raising out_ready then pops the result and accepts the new operands on the same edge.
- Back-to-back: out_ready=1 and in_valid=1 continuously, with 3 distinct operand sets → results in order at 9-cycle spacing, each matching the reference model.
- Reset mid-operation: assert rst at the 4th CALC cycle → out_valid=0, C_data_out=0, busy=0 and in_ready=1 without waiting for a clock edge. After release, a new operation completes correctly.
- Generalised config: STEP=4, B_COLS=2; A_data_in=32'h08040201, B_data_in=16'h00FF → out_valid 2 cycles after acceptance; C_data_out=8'hFF.

Source files
------------

// File: rtl/mat_mult_seq.sv
// mat_mult_seq: sequential GF(2) matrix multiplier, C = A x B (AND multiply, XOR add).
// The inner dimension is consumed STEP terms per cycle over NSTEP = A_COLS/STEP cycles.
// Results are held until the consumer accepts them, and a new operand set can be taken
// on the same edge as the pop.
// Optional feature macro: MAT_MULT_SEQ_PARITY_EN adds C_parity, the XOR of all result bits.
module mat_mult_seq #(
  parameter int A_ROWS = 4,
  parameter int A_COLS = 8,
  parameter int B_COLS = 1,
  parameter int STEP   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [A_ROWS*A_COLS-1:0]   A_data_in,
  input  logic [A_COLS*B_COLS-1:0]   B_data_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [A_ROWS*B_COLS-1:0]   C_data_out,
  output logic                       busy
`ifdef MAT_MULT_SEQ_PARITY_EN
  ,
  output logic                       C_parity
`endif
);

  localparam int KW = (A_COLS > 1) ? $clog2(A_COLS) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(A_COLS - STEP);
  localparam logic [KW-1:0] K_INC  = KW'(STEP);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t                     state;
  logic [A_ROWS*A_COLS-1:0]   a_reg;
  logic [A_COLS*B_COLS-1:0]   b_reg;
  logic [A_ROWS*B_COLS-1:0]   acc;
  logic [A_ROWS*B_COLS-1:0]   acc_next;
  logic [KW-1:0]              k_cnt;
  logic [A_COLS-1:0]          win;
  logic                       last_step;

  // Ready and busy come from registered state; out_ready is the only combinational input.
  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  assign busy      = (state != IDLE);
  assign last_step = (k_cnt == K_LAST);

  // Select which inner-dimension terms belong to the current step.
  always_comb begin
    win = '0;
    for (int k = 0; k < A_COLS; k++) begin
      win[k] = (k >= int'(k_cnt)) && (k < int'(k_cnt) + STEP);
    end
  end

  // Fold the AND products of the active window into the running XOR accumulator.
  always_comb begin
    acc_next = acc;
    for (int r = 0; r < A_ROWS; r++) begin
      for (int c = 0; c < B_COLS; c++) begin
        for (int k = 0; k < A_COLS; k++) begin
          acc_next[r*B_COLS+c] ^= win[k] & a_reg[r*A_COLS+k] & b_reg[k*B_COLS+c];
        end
      end
    end
  end

  // Control FSM with operand capture, accumulation and registered result/handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      acc        <= '0;
      k_cnt      <= '0;
      out_valid  <= 1'b0;
      C_data_out <= '0;
`ifdef MAT_MULT_SEQ_PARITY_EN
      C_parity   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= A_data_in;
            b_reg <= B_data_in;
            acc   <= '0;
            k_cnt <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          acc   <= acc_next;
          k_cnt <= k_cnt + K_INC;
          if (last_step) begin
            C_data_out <= acc_next;
`ifdef MAT_MULT_SEQ_PARITY_EN
            C_parity   <= ^acc_next;
`endif
            out_valid  <= 1'b1;
            k_cnt      <= '0;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              a_reg <= A_data_in;
              b_reg <= B_data_in;
              acc   <= '0;
              k_cnt <= '0;
              state <= CALC;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mat_mult_seq.sv
// Testbench for mat_mult_seq: a default-parameter instance and a STEP=4, B_COLS=2 instance,
// both checked against a whole-matrix GF(2) product computed in the bench.
module tb_mat_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [31:0] a_in;
  logic [7:0]  b_in;
  logic [3:0]  c_out;
  logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
  logic [31:0] a_in2;
  logic [15:0] b_in2;
  logic [7:0]  c_out2;
`ifdef MAT_MULT_SEQ_PARITY_EN
  logic        c_parity, c_parity2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mat_mult_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A_data_in(a_in), .B_data_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .C_data_out(c_out), .busy(busy)
`ifdef MAT_MULT_SEQ_PARITY_EN
    , .C_parity(c_parity)
`endif
  );

  mat_mult_seq #(.A_ROWS(4), .A_COLS(8), .B_COLS(2), .STEP(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
    .A_data_in(a_in2), .B_data_in(b_in2), .out_valid(out_valid2), .out_ready(out_ready2),
    .C_data_out(c_out2), .busy(busy2)
`ifdef MAT_MULT_SEQ_PARITY_EN
    , .C_parity(c_parity2)
`endif
  );

  // Plain matrix product over GF(2): C(r,c) = XOR_k A(r,k) & B(k,c)
  function automatic logic [63:0] ref_mult(input logic [63:0] a, input logic [63:0] b,
                                           input int rows, input int inner, input int bcols);
    logic [63:0] c;
    logic        s;
    c = '0;
    for (int r = 0; r < rows; r++) begin
      for (int cc = 0; cc < bcols; cc++) begin
        s = 1'b0;
        for (int k = 0; k < inner; k++) s = s ^ (a[r*inner+k] & b[k*bcols+cc]);
        c[r*bcols+cc] = s;
      end
    end
    return c;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One full operation on the default instance: accept, measure latency, check, pop.
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [7:0] b);
    int lat;
    logic [3:0] exp;
    exp = 4'(ref_mult(64'(a), 64'(b), 4, 8, 1));
    @(negedge clk);
    checkOutput({tag, " in_ready"}, 64'(in_ready), 64'(1));
    a_in = a; b_in = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a_in = $urandom; b_in = 8'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, " latency"}, 64'(lat), 64'(8));
    checkOutput({tag, " C"}, 64'(c_out), 64'(exp));
`ifdef MAT_MULT_SEQ_PARITY_EN
    checkOutput({tag, " parity"}, 64'(c_parity), 64'(^exp));
`endif
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput({tag, " popped"}, 64'(out_valid), 64'(0));
    checkOutput({tag, " C held"}, 64'(c_out), 64'(exp));
    @(negedge clk); out_ready = 1'b0;
  endtask

  // One operation on the STEP=4, B_COLS=2 instance (consumer always ready).
  task automatic applyStimulus2(input string tag, input logic [31:0] a, input logic [15:0] b);
    int lat;
    logic [7:0] exp;
    exp = 8'(ref_mult(64'(a), 64'(b), 4, 8, 2));
    @(negedge clk);
    a_in2 = a; b_in2 = b; in_valid2 = 1'b1;
    @(posedge clk); #1;
    in_valid2 = 1'b0; a_in2 = $urandom; b_in2 = 16'($urandom);
    lat = 0;
    while (!out_valid2 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, " latency"}, 64'(lat), 64'(2));
    checkOutput({tag, " C"}, 64'(c_out2), 64'(exp));
    @(posedge clk); #1;
    checkOutput({tag, " popped"}, 64'(out_valid2), 64'(0));
  endtask

  initial begin
    logic [31:0] qa [3];
    logic [7:0]  qb [3];
    logic [3:0]  expq [$];
    int          rcyc [$];
    int          idx, got, cyc, lat;
    bit          accept;
    logic [3:0]  exp1, exp3;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b1; a_in2 = '0; b_in2 = '0;
    #1;
    checkOutput("reset out_valid", 64'(out_valid), 64'(0));
    checkOutput("reset C", 64'(c_out), 64'(0));
    checkOutput("reset busy", 64'(busy), 64'(0));
    checkOutput("reset in_ready", 64'(in_ready), 64'(1));
`ifdef MAT_MULT_SEQ_PARITY_EN
    checkOutput("reset parity", 64'(c_parity), 64'(0));
`endif
    @(negedge clk); @(negedge clk); rst = 1'b0;

    applyStimulus("identity", 32'h08040201, 8'h0F);
    applyStimulus("parity7", 32'hFFFFFFFF, 8'h07);
    applyStimulus("parity3", 32'hFFFFFFFF, 8'h03);
    for (int i = 0; i < 4; i++) applyStimulus("random", $urandom, 8'($urandom));

    // Backpressure: result must stay put while new operands wait.
    exp1 = 4'(ref_mult(64'(32'h08040201), 64'(8'h05), 4, 8, 1));
    exp3 = 4'(ref_mult(64'(32'h08040201), 64'(8'h0F), 4, 8, 1));
    @(negedge clk); a_in = 32'h08040201; b_in = 8'h05; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    checkOutput("bp first C", 64'(c_out), 64'(exp1));
    @(negedge clk); a_in = 32'hFFFFFFFF; b_in = 8'h03; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bp out_valid", 64'(out_valid), 64'(1));
      checkOutput("bp in_ready", 64'(in_ready), 64'(0));
      checkOutput("bp C stable", 64'(c_out), 64'(exp1));
    end
    @(negedge clk); a_in = 32'h08040201; b_in = 8'h0F; out_ready = 1'b1;
    #1 checkOutput("bp in_ready follows", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checkOutput("bp popped", 64'(out_valid), 64'(0));
    checkOutput("bp busy", 64'(busy), 64'(1));
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    checkOutput("bp latency", 64'(lat), 64'(8));
    checkOutput("bp second C", 64'(c_out), 64'(exp3));
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;

    // Back-to-back: three operand sets with both handshakes held high.
    for (int i = 0; i < 3; i++) begin qa[i] = $urandom; qb[i] = 8'($urandom); end
    idx = 0; got = 0; cyc = 0;
    @(negedge clk); out_ready = 1'b1; a_in = qa[0]; b_in = qb[0]; in_valid = 1'b1;
    while (got < 3 && cyc < 100) begin
      if (out_valid) begin
        if (expq.size() > 0) checkOutput("b2b C", 64'(c_out), 64'(expq.pop_front()));
        else checkOutput("b2b unexpected result", 64'(out_valid), 64'(0));
        rcyc.push_back(cyc);
        got++;
      end
      accept = in_valid && in_ready;
      if (accept) expq.push_back(4'(ref_mult(64'(a_in), 64'(b_in), 4, 8, 1)));
      @(negedge clk); cyc++;
      if (accept) begin
        idx++;
        if (idx < 3) begin a_in = qa[idx]; b_in = qb[idx]; end
        else in_valid = 1'b0;
      end
    end
    checkOutput("b2b count", 64'(got), 64'(3));
    if (rcyc.size() >= 3) begin
      checkOutput("b2b first latency", 64'(rcyc[0]), 64'(9));
      checkOutput("b2b gap1", 64'(rcyc[1] - rcyc[0]), 64'(9));
      checkOutput("b2b gap2", 64'(rcyc[2] - rcyc[1]), 64'(9));
    end
    in_valid = 1'b0;
    @(negedge clk); out_ready = 1'b0;

    // Reset mid-operation, after a nonzero result so the clearing of C is visible.
    applyStimulus("pre-reset", 32'h08040201, 8'h0F);
    @(negedge clk); a_in = $urandom; b_in = 8'($urandom); in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midreset out_valid", 64'(out_valid), 64'(0));
    checkOutput("midreset C", 64'(c_out), 64'(0));
    checkOutput("midreset busy", 64'(busy), 64'(0));
    checkOutput("midreset in_ready", 64'(in_ready), 64'(1));
`ifdef MAT_MULT_SEQ_PARITY_EN
    checkOutput("midreset parity", 64'(c_parity), 64'(0));
`endif
    @(negedge clk); rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 checkOutput("discarded result", 64'(out_valid), 64'(0));
    applyStimulus("post-reset", $urandom, 8'($urandom));

    // Wider configuration instance.
    applyStimulus2("cfg2 identity", 32'h08040201, 16'h00FF);
    for (int i = 0; i < 3; i++) applyStimulus2("cfg2 random", $urandom, 16'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
